exc_request_ctrl: RTL

- Source side of the processor's exception handshake.
- Collects exception/interrupt events from NSRC sources and masks them. Picks the highest-priority pending event.
- Drives the Exc level and 4-bit EStatus code into the pipeline's exception unit. Holds the request until ExcAck, then blocks further requests until the handler executes ERET.
- One clock domain. Sits beside the fetch stage.

---
 rtl/exc_pkg.sv | 8 +
 rtl/exc_request_ctrl_if.sv | 16 +
 rtl/prio_enc.sv | 17 +
 rtl/exc_request_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared exception-request types and constants.
package exc_pkg;
    localparam int EST_W = 4;
    localparam logic [EST_W-1:0] EST_NONE = 4'h0;
    localparam logic [63:0] EXC_VECTOR = 64'hd8;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/exc_request_ctrl_if.sv
// exc_request_ctrl_if: event inputs and exception request handshake of the request controller.
interface exc_request_ctrl_if #(parameter int NSRC = 4);
    import exc_pkg::*;
    logic [NSRC-1:0] src;
    logic [NSRC-1:0] mask_d;
    logic [NSRC-1:0] pending;
    logic mask_we;
    logic ExcAck;
    logic ERet;
    logic Exc;
    logic busy;
    logic [EST_W-1:0] EStatus;

    modport master (input src, mask_we, mask_d, ExcAck, ERet, output Exc, EStatus, busy, pending);
    modport slave (output src, mask_we, mask_d, ExcAck, ERet, input Exc, EStatus, busy, pending);
endinterface

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-first priority encoder with valid flag.
module prio_enc
    import exc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    output logic [EST_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = EST_W'(i);
        valid = |req;
    end
endmodule

// File: rtl/exc_request_ctrl.sv
// exc_request_ctrl: captures and masks event sources, raises one prioritised exception
// request at a time and blocks further requests until the handler returns.
module exc_request_ctrl
    import exc_pkg::*;
#(
    parameter int NSRC = 4,
    parameter bit EDGE = 1'b1
) (
    input logic clk,
    input logic reset,
    exc_request_ctrl_if.master bus
);
    state_t state, state_n;
    logic [NSRC-1:0] pending, mask, src_q, hit, clr;
    logic [EST_W-1:0] sel, sel_n, win, est, est_n;
    logic exc, exc_n, busy, win_v;

    prio_enc #(.N(NSRC)) u_prio (.req(pending & mask), .idx(win), .valid(win_v));

    assign hit = EDGE ? bus.src & ~src_q : bus.src;

    // Only the acknowledged source is cleared; a same-cycle new event still sets it.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NSRC; i++)
            clr[i] = state == REQ && bus.ExcAck && sel == EST_W'(i);
    end

    always_comb begin
        state_n = state;
        sel_n = sel;
        exc_n = exc;
        est_n = est;
        case (state)
            IDLE: if (win_v) begin
                state_n = REQ;
                sel_n = win;
                exc_n = 1'b1;
                est_n = win + EST_W'(1);
            end
            REQ: if (bus.ExcAck) begin
                state_n = SERVICE;
                exc_n = 1'b0;
            end
            SERVICE: if (bus.ERet) begin
                state_n = IDLE;
                est_n = EST_NONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            sel <= '0;
            exc <= 1'b0;
            est <= EST_NONE;
            busy <= 1'b0;
            pending <= '0;
            mask <= '1;
            src_q <= '0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            exc <= exc_n;
            est <= est_n;
            busy <= state_n != IDLE;
            pending <= (pending & ~clr) | hit;
            mask <= bus.mask_we ? bus.mask_d : mask;
            src_q <= bus.src;
        end

    assign bus.Exc = exc;
    assign bus.EStatus = est;
    assign bus.busy = busy;
    assign bus.pending = pending;
endmodule
